// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB definitions: bus widths, requester indices and the broadcast record.
package cdb_arbiter_pkg;

    localparam int CDB_NUM_REQ = 3;
    localparam int CDB_TAG_W   = 3;
    localparam int CDB_DATA_W  = 32;

    localparam int CDB_REQ_ALU = 0;
    localparam int CDB_REQ_BR  = 1;
    localparam int CDB_REQ_LS  = 2;

    typedef struct packed {
        logic                  valid;
        logic [CDB_TAG_W-1:0]  tag;
        logic [CDB_DATA_W-1:0] data;
    } cdb_t;

    // Index width that stays legal for a single requester.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// Combinational rotate-priority picker: first set request at or after ptr, modulo NUM_REQ.
module rr_pick
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = CDB_NUM_REQ,
    parameter int PTR_W   = ptr_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   idx,
    output logic               found
);

    logic [PTR_W:0] cand_s;

    // Scan ptr, ptr+1, ... with an explicit wrap so non-power-of-2 counts work.
    always_comb begin
        grant  = {NUM_REQ{1'b0}};
        idx    = {PTR_W{1'b0}};
        found  = 1'b0;
        cand_s = {(PTR_W+1){1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_s = {1'b0, ptr} + (PTR_W+1)'(i);
            if (cand_s >= (PTR_W+1)'(NUM_REQ)) begin
                cand_s = cand_s - (PTR_W+1)'(NUM_REQ);
            end else begin
                cand_s = cand_s;
            end
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!found && req[j] && (cand_s == (PTR_W+1)'(j))) begin
                    grant[j] = 1'b1;
                    idx      = PTR_W'(j);
                    found    = 1'b1;
                end else begin
                    found = found;
                end
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the common data bus: grants one FU result per cycle and
// registers it as the broadcast seen by the ROB and reservation stations.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = CDB_NUM_REQ,
    parameter int TAG_W   = CDB_TAG_W,
    parameter int DATA_W  = CDB_DATA_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ack,
    output logic                      cdb_valid,
    output logic [TAG_W-1:0]          cdb_tag,
    output logic [DATA_W-1:0]         cdb_data
);

    localparam int PTR_W = ptr_width(NUM_REQ);

    logic [PTR_W-1:0]   rr_ptr_r;
    logic [PTR_W-1:0]   nxt_ptr_s;
    logic [NUM_REQ-1:0] grant_s;
    logic [PTR_W-1:0]   idx_s;
    logic               found_s;
    logic               grant_en_s;
    logic [TAG_W-1:0]   win_tag_s;
    logic [DATA_W-1:0]  win_data_s;
    logic               cdb_valid_r;
    logic [TAG_W-1:0]   cdb_tag_r;
    logic [DATA_W-1:0]  cdb_data_r;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr_r),
        .grant (grant_s),
        .idx   (idx_s),
        .found (found_s)
    );

    // Reset and flush both suppress the grant so no FU retires a result that is dropped.
    always_comb begin
        grant_en_s = found_s & ~rst & ~flush;
        if (grant_en_s) begin
            req_ack = grant_s;
        end else begin
            req_ack = {NUM_REQ{1'b0}};
        end
    end

    // One-hot AND-OR mux of the winning tag/data and the wrapped successor pointer.
    always_comb begin
        win_tag_s  = {TAG_W{1'b0}};
        win_data_s = {DATA_W{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_s[i]) begin
                win_tag_s  = win_tag_s  | req_tag[i*TAG_W +: TAG_W];
                win_data_s = win_data_s | req_data[i*DATA_W +: DATA_W];
            end else begin
                win_tag_s  = win_tag_s;
                win_data_s = win_data_s;
            end
        end
        if (idx_s == PTR_W'(NUM_REQ-1)) begin
            nxt_ptr_s = {PTR_W{1'b0}};
        end else begin
            nxt_ptr_s = idx_s + PTR_W'(1);
        end
    end

    // Broadcast register; tag/data hold across idle and flushed cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            cdb_valid_r <= 1'b0;
            cdb_tag_r   <= {TAG_W{1'b0}};
            cdb_data_r  <= {DATA_W{1'b0}};
        end else if (grant_en_s) begin
            cdb_valid_r <= 1'b1;
            cdb_tag_r   <= win_tag_s;
            cdb_data_r  <= win_data_s;
        end else begin
            cdb_valid_r <= 1'b0;
        end
    end

    // Round-robin pointer: restart at FU0 after reset or flush, advance past each winner.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rr_ptr_r <= {PTR_W{1'b0}};
        end else if (found_s) begin
            rr_ptr_r <= nxt_ptr_s;
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    assign cdb_valid = cdb_valid_r;
    assign cdb_tag   = cdb_tag_r;
    assign cdb_data  = cdb_data_r;

endmodule
